// File: rtl/line_scan.sv
// line_scan
// ---------
// Consumer-side scanner for obstacle lines. A start request captures one line
// together with the player's horizontal span. The block then walks the line one
// pixel per clock and reports three things: how many passable gaps the line has,
// where the first gap begins, and whether any wall pixel lies inside the player
// span.
//
// Optional feature macro: LINE_SCAN_LONGEST_EN
//   defined     -> longest_o reports the longest 0-run of the last scanned line
//   not defined -> the tracker is not built and longest_o is tied to 0
//
// Ports
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset
//   start_i      : scan request, only looked at while idle
//   line_i       : line to scan (1 = wall, 0 = open, bit 0 scanned first)
//   player_x_i   : leftmost pixel of the player
//   player_w_i   : player width in pixels (0 never collides)
//   busy_o       : scan in progress
//   done_o       : one-cycle pulse when the result outputs update
//   gap_count_o  : number of 0-runs of at least GapWidth pixels, saturating at 255
//   first_gap_o  : start index of the first such run, all ones if there is none
//   collide_o    : a wall pixel lies inside [player_x, player_x + player_w)
//   longest_o    : longest 0-run in the line (only with LINE_SCAN_LONGEST_EN)
module line_scan #(
  parameter int Width    = 640,
  parameter int GapWidth = 80,
  parameter int PosW     = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [Width-1:0]  line_i,
  input  logic [PosW-1:0]   player_x_i,
  input  logic [PosW-1:0]   player_w_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        gap_count_o,
  output logic [PosW-1:0]   first_gap_o,
  output logic              collide_o,
  output logic [PosW:0]     longest_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [PosW-1:0] IdxLast  = PosW'(Width - 1);
  localparam logic [PosW:0]   WidthExt = (PosW + 1)'(Width);
  localparam logic [PosW:0]   GapMin   = (PosW + 1)'(GapWidth);
  localparam logic [PosW-1:0] NoGap    = {PosW{1'b1}};

  state_e            state_q, state_d;
  logic [Width-1:0]  line_q, line_d;
  logic [PosW-1:0]   px_q, px_d;
  logic [PosW-1:0]   pw_q, pw_d;
  logic [PosW-1:0]   idx_q, idx_d;
  logic [PosW:0]     run_q, run_d;
  logic [7:0]        gap_acc_q, gap_acc_d;
  logic [PosW-1:0]   first_acc_q, first_acc_d;
  logic              coll_acc_q, coll_acc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        gap_count_q, gap_count_d;
  logic [PosW-1:0]   first_gap_q, first_gap_d;
  logic              collide_q, collide_d;

  // Per-pixel helpers for the scan step
  logic              bit_s;
  logic              last_s;
  logic [PosW:0]     run_inc_s;
  logic              close_s;
  logic [PosW:0]     run_len_s;
  logic [PosW:0]     gap_start_s;
  logic              in_span_s;
  logic [PosW:0]     span_end_s;

  // Decode the current shadow pixel and what it means for the open run
  always_comb begin
    bit_s      = line_q[idx_q];
    last_s     = (idx_q == IdxLast);
    run_inc_s  = (run_q == WidthExt) ? run_q : (run_q + (PosW + 1)'(1));
    // A run closes on a wall after open pixels, or unconditionally at the end of line
    close_s    = (bit_s && (run_q != (PosW + 1)'(0))) || last_s;
    // The final pixel belongs to the run when it is open
    run_len_s  = bit_s ? run_q : run_inc_s;
    if (bit_s) begin
      gap_start_s = {1'b0, idx_q} - run_len_s;
    end else begin
      gap_start_s = WidthExt - run_len_s;
    end
    // Span end is widened by one bit so px+pw cannot wrap; idx < Width clips it
    span_end_s = {1'b0, px_q} + {1'b0, pw_q};
    in_span_s  = ({1'b0, idx_q} >= {1'b0, px_q}) && ({1'b0, idx_q} < span_end_s);
  end

`ifdef LINE_SCAN_LONGEST_EN
  logic [PosW:0] longest_acc_q, longest_acc_d;
  logic [PosW:0] longest_q, longest_d;

  // Longest-run tracker: cleared on start, updated at each run close, published at DONE
  always_comb begin
    longest_acc_d = longest_acc_q;
    longest_d     = longest_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          longest_acc_d = (PosW + 1)'(0);
        end else begin
          longest_acc_d = longest_acc_q;
        end
      end
      SCAN: begin
        if (close_s && (run_len_s > longest_acc_q)) begin
          longest_acc_d = run_len_s;
        end else begin
          longest_acc_d = longest_acc_q;
        end
      end
      DONE: begin
        longest_d = longest_acc_q;
      end
      default: begin
        longest_acc_d = (PosW + 1)'(0);
      end
    endcase
  end

  // Longest-run registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      longest_acc_q <= (PosW + 1)'(0);
      longest_q     <= (PosW + 1)'(0);
    end else begin
      longest_acc_q <= longest_acc_d;
      longest_q     <= longest_d;
    end
  end

  assign longest_o = longest_q;
`else
  assign longest_o = (PosW + 1)'(0);
`endif

  // Next-state logic for the scan FSM, accumulators and result registers
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    px_d        = px_q;
    pw_d        = pw_q;
    idx_d       = idx_q;
    run_d       = run_q;
    gap_acc_d   = gap_acc_q;
    first_acc_d = first_acc_q;
    coll_acc_d  = coll_acc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    gap_count_d = gap_count_q;
    first_gap_d = first_gap_q;
    collide_d   = collide_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = SCAN;
          line_d      = line_i;
          px_d        = player_x_i;
          pw_d        = player_w_i;
          idx_d       = PosW'(0);
          run_d       = (PosW + 1)'(0);
          gap_acc_d   = 8'd0;
          first_acc_d = NoGap;
          coll_acc_d  = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        idx_d = idx_q + PosW'(1);
        if (close_s) begin
          run_d = (PosW + 1)'(0);
          if (run_len_s >= GapMin) begin
            if (gap_acc_q == 8'd0) begin
              first_acc_d = gap_start_s[PosW-1:0];
            end else begin
              first_acc_d = first_acc_q;
            end
            if (gap_acc_q != 8'hFF) begin
              gap_acc_d = gap_acc_q + 8'd1;
            end else begin
              gap_acc_d = gap_acc_q;
            end
          end else begin
            gap_acc_d = gap_acc_q;
          end
        end else if (!bit_s) begin
          run_d = run_inc_s;
        end else begin
          run_d = run_q;
        end
        if (bit_s && in_span_s) begin
          coll_acc_d = 1'b1;
        end else begin
          coll_acc_d = coll_acc_q;
        end
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        gap_count_d = gap_acc_q;
        first_gap_d = first_acc_q;
        collide_d   = coll_acc_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, shadow, accumulator and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      line_q      <= {Width{1'b0}};
      px_q        <= PosW'(0);
      pw_q        <= PosW'(0);
      idx_q       <= PosW'(0);
      run_q       <= (PosW + 1)'(0);
      gap_acc_q   <= 8'd0;
      first_acc_q <= NoGap;
      coll_acc_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gap_count_q <= 8'd0;
      first_gap_q <= NoGap;
      collide_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      px_q        <= px_d;
      pw_q        <= pw_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      gap_acc_q   <= gap_acc_d;
      first_acc_q <= first_acc_d;
      coll_acc_q  <= coll_acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gap_count_q <= gap_count_d;
      first_gap_q <= first_gap_d;
      collide_q   <= collide_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign gap_count_o = gap_count_q;
  assign first_gap_o = first_gap_q;
  assign collide_o   = collide_q;

endmodule

// File: tb/tb_line_scan.sv
// Self-checking bench for line_scan: directed cases plus randomized lines,
// compared against a run-list model of gaps, first gap, longest run and span hits.
module tb_line_scan;

  localparam int W = 640;

  logic          clk_i;
  logic          rst_i;
  logic          start_i;
  logic [W-1:0]  line_i;
  logic [9:0]    player_x_i;
  logic [9:0]    player_w_i;
  logic          busy_o;
  logic          done_o;
  logic [7:0]    gap_count_o;
  logic [9:0]    first_gap_o;
  logic          collide_o;
  logic [10:0]   longest_o;

  int checks;
  int failures;

  line_scan dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .line_i      (line_i),
    .player_x_i  (player_x_i),
    .player_w_i  (player_w_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .gap_count_o (gap_count_o),
    .first_gap_o (first_gap_o),
    .collide_o   (collide_o),
    .longest_o   (longest_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: list the 0-runs of the line and test the player span pixel by pixel.
  task automatic model(input logic [W-1:0] ln, input int px, input int pw,
                       output int cnt, output int first, output int coll, output int lng);
    int i;
    int s;
    int len;
    cnt = 0; first = 1023; coll = 0; lng = 0; i = 0;
    while (i < W) begin
      if (ln[i] == 1'b0) begin
        s = i;
        while (i < W && ln[i] == 1'b0) i++;
        len = i - s;
        if (len >= 80) begin
          if (cnt == 0) first = s;
          if (cnt < 255) cnt++;
        end
        if (len > lng) lng = len;
      end else begin
        i++;
      end
    end
    for (int j = px; j < px + pw && j < W; j++) begin
      if (ln[j]) coll = 1;
    end
  endtask

  function automatic logic [W-1:0] zeros_at(input int lo, input int hi);
    logic [W-1:0] v;
    v = '1;
    for (int i = lo; i <= hi; i++) v[i] = 1'b0;
    return v;
  endfunction

  function automatic logic [W-1:0] random_line();
    logic [W-1:0] v;
    int pos;
    int len;
    logic val;
    v = '1;
    pos = 0;
    val = 1'($urandom_range(0, 1));
    while (pos < W) begin
      len = (val == 1'b0) ? int'($urandom_range(1, 160)) : int'($urandom_range(1, 40));
      for (int i = 0; i < len && pos < W; i++) begin
        v[pos] = val;
        pos++;
      end
      val = ~val;
    end
    return v;
  endfunction

  task automatic scramble_inputs();
    for (int w = 0; w < W / 32; w++) line_i[w*32 +: 32] = $urandom();
    player_x_i = 10'($urandom());
    player_w_i = 10'($urandom());
  endtask

  // One full scan with latency, busy, single-done and result checks.
  // hold_at > 0 raises start_i for ten cycles from that scan cycle on.
  task automatic do_scan(input string tag, input logic [W-1:0] ln, input int px,
                         input int pw, input int hold_at);
    int e_cnt, e_first, e_coll, e_lng;
    int latency, dones, busy_bad;
    model(ln, px, pw, e_cnt, e_first, e_coll, e_lng);
`ifndef LINE_SCAN_LONGEST_EN
    e_lng = 0;
`endif
    @(negedge clk_i);
    line_i = ln;
    player_x_i = 10'(px);
    player_w_i = 10'(pw);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check_eq({tag, ".busy_start"}, 32'(busy_o), 32'd1);
    latency = 0; dones = 0; busy_bad = 0;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clk_i);
      #1;
      if (done_o) begin
        dones++;
        if (latency == 0) latency = n;
      end else if (latency == 0 && !busy_o) begin
        busy_bad++;
      end
      if (latency == 0) scramble_inputs();
      if (hold_at > 0 && n == hold_at) start_i = 1'b1;
      if (hold_at > 0 && n == hold_at + 10) start_i = 1'b0;
    end
    check_eq({tag, ".latency"}, 32'(latency), 32'd641);
    check_eq({tag, ".dones"}, 32'(dones), 32'd1);
    check_eq({tag, ".busy_gaps"}, 32'(busy_bad), 32'd0);
    check_eq({tag, ".busy_end"}, 32'(busy_o), 32'd0);
    check_eq({tag, ".count"}, 32'(gap_count_o), 32'(e_cnt));
    check_eq({tag, ".first"}, 32'(first_gap_o), 32'(e_first));
    check_eq({tag, ".collide"}, 32'(collide_o), 32'(e_coll));
    check_eq({tag, ".longest"}, 32'(longest_o), 32'(e_lng));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, ".done"}, 32'(done_o), 32'd0);
    check_eq({tag, ".count"}, 32'(gap_count_o), 32'd0);
    check_eq({tag, ".first"}, 32'(first_gap_o), 32'h3FF);
    check_eq({tag, ".collide"}, 32'(collide_o), 32'd0);
    check_eq({tag, ".longest"}, 32'(longest_o), 32'd0);
  endtask

  initial begin
    int dones;
    int busy_seen;
    logic [W-1:0] ln;
    checks = 0;
    failures = 0;
    rst_i = 1'b1;
    start_i = 1'b0;
    line_i = '0;
    player_x_i = 10'd0;
    player_w_i = 10'd0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases
    do_scan("ones", '1, 100, 20, 0);
    do_scan("gap100", zeros_at(100, 179), 120, 40, 0);
    do_scan("gap100_hit", zeros_at(100, 179), 170, 20, 0);
    do_scan("gap79", zeros_at(300, 378), 0, 0, 0);
    do_scan("gap_end", zeros_at(560, 639), 0, 10, 0);
    do_scan("zeros", '0, 0, 640, 0);
    do_scan("clip", '1, 630, 20, 0);
    do_scan("pw0", '1, 300, 0, 0);
    do_scan("px_far", '1, 1000, 50, 0);
    ln = zeros_at(0, 99) & zeros_at(200, 299) & zeros_at(400, 480);
    do_scan("three", ln, 99, 2, 0);
    do_scan("hold_start", zeros_at(10, 200), 5, 5, 50);

    // Reset mid-scan, with non-reset results on the outputs beforehand
    do_scan("pre_rst", zeros_at(100, 179), 170, 20, 0);
    @(negedge clk_i);
    line_i = zeros_at(20, 300);
    player_x_i = 10'd0;
    player_w_i = 10'd30;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (300) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk_i);
    rst_i = 1'b0;
    dones = 0;
    busy_seen = 0;
    for (int n = 0; n < 700; n++) begin
      @(posedge clk_i);
      #1;
      if (done_o) dones++;
      if (busy_o) busy_seen++;
    end
    check_eq("rst_mid.no_done", 32'(dones), 32'd0);
    check_eq("rst_mid.no_busy", 32'(busy_seen), 32'd0);
    check_reset_values("rst_after");
    do_scan("post_rst", zeros_at(20, 300), 0, 30, 0);

    // Randomized lines and spans
    for (int t = 0; t < 16; t++) begin
      int px;
      int pw;
      px = (t % 4 == 3) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 639));
      pw = (t % 5 == 4) ? 0 : int'($urandom_range(1, 120));
      do_scan($sformatf("rand%0d", t), random_line(), px, pw, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_scan.md
# line_scan

Consumer-side scanner for the 640-pixel obstacle lines produced by the line generator. On a start request it snapshots one line plus the player's horizontal span, walks the line one pixel per clock, and reports how many passable gaps the line contains, where the first one begins, and whether the player span overlaps any wall pixel. It sits between the line generator and the game-state logic, which uses the results to decide survival and scoring.

## Interface
Parameters:
- `Width`, 640, pixels per line.
- `GapWidth`, 80, minimum run of consecutive 0 pixels that counts as a gap.
- `PosW`, 10, width of pixel index and position fields (2^PosW must be ≥ Width).

Ports:
- `clk_i` in 1: the block's single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `start_i` in 1: scan request, sampled only in IDLE.
- `line_i` in Width: line to scan; bit 1 = wall, bit 0 = open; index 0 is scanned first.
- `player_x_i` in PosW: leftmost pixel index of the player.
- `player_w_i` in PosW: player width in pixels.
- `busy_o` out 1: scan in progress.
- `done_o` out 1: one-cycle pulse when the results update.
- `gap_count_o` out 8: number of qualifying gaps; saturates at 255.
- `first_gap_o` out PosW: start index of the first qualifying gap; all ones if there is none.
- `collide_o` out 1: a wall pixel lies inside the player span.
- `longest_o` out PosW+1: longest 0-run in the line (present only with the macro).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE → SCAN when `start_i`=1:
  - capture `line_i`, `player_x_i`, `player_w_i` into shadow registers;
  - clear the index, run counter and the working accumulators;
  - assert `busy_o`.
- SCAN examines shadow bit `idx` once per cycle, with `idx` running 0..Width-1.
  - Bit 0: run counter +1, saturating at Width.
  - Run close: triggered by bit 1 after a run, or by reaching `idx`=Width-1 (the final bit is included in the run if it is 0).
    - If run ≥ GapWidth: gap count +1 (saturating).
    - If no gap has been recorded yet: first gap = `idx` − run (or Width − run for an end-of-line close).
    - Reset the run counter.
  - Collision: if bit=1 and px ≤ idx < px+pw, set the collide accumulator.
    - px+pw is computed in PosW+1 bits with no wrap.
    - The span is clipped at Width.
    - pw=0 never collides.
  - At `idx`=Width-1 → DONE.
- DONE: copy the accumulators to the output registers, pulse `done_o`, clear `busy_o`, → IDLE.
- `start_i` during SCAN or DONE is ignored; it is not queued.
- Outputs hold their last results until the next DONE.
- Changing `line_i` or the player inputs mid-scan has no effect, because the shadow copies are used.

## Timing
- Reset values:
  - state IDLE, `busy_o`=0, `done_o`=0;
  - `gap_count_o`=0, `first_gap_o`=all ones, `collide_o`=0, `longest_o`=0.
- Clock edge k samples `start_i`=1. `busy_o`=1 from k to k+Width.
- Bit i is evaluated at edge k+1+i.
- At edge k+Width+1, `done_o`=1 and the results update, both in the same cycle. `busy_o`=0 from that edge.
- Latency from start to done: Width+1 edges (641 by default). The next start is accepted at edge k+Width+2 at the earliest.
- Reset asserted at any time aborts the scan immediately. There is no `done_o` pulse and all outputs take their reset values.

## Configuration
- `LINE_SCAN_LONGEST_EN` defined:
  - a PosW+1 bit longest-run tracker is updated at every run close;
  - `longest_o` is driven from it at DONE.
- Not defined:
  - the tracker is not built;
  - `longest_o` is tied to 0;
  - all other behaviour is identical.

## Test plan
- Line all ones, px=100, pw=20, start: `done_o` exactly 641 edges later; `gap_count_o`=0, `first_gap_o`=0x3FF, `collide_o`=1, `longest_o`=0.
- Zeros at 100..179, ones elsewhere:
  - px=120, pw=40: count 1, first 100, collide 0, longest 80;
  - rerun with px=170, pw=20: collide 1.
- Gap boundaries:
  - zeros at 300..378 (79 wide): count 0, first 0x3FF;
  - zeros at 560..639: count 1, first 560 (end-of-line close).
- All zeros, px=0, pw=640: count 1, first 0, collide 0, longest 640.
- Clipping and zero width:
  - ones line, px=630, pw=20: collide 1 (span clipped to 630..639);
  - pw=0: collide 0.
- Control:
  - `start_i` held high at scan cycle 50: ignored, single `done_o`;
  - `rst_i` pulsed at scan cycle 300: `busy_o`=0 at once, no `done_o`, outputs at reset values;
  - a new start then completes normally.
